// File: rtl/hc161_timer_ctrl_if.sv
// Control bundle between the timer controller (master) and an HC161-style
// presettable up-counter (slave).
interface hc161_timer_ctrl_if #(
  parameter int WIDTH = 4
);
  // Handshake semantics: there is no valid/ready pair. The controller owns
  // cnt_pe_n/cnt_cep/cnt_cet/cnt_d every cycle. The counter acts on them at the
  // next rising edge: load has priority, then count when cep & cet are both high.
  // cnt_q and cnt_tc show the counter state for the current cycle.
  logic             cnt_pe_n;
  logic             cnt_cep;
  logic             cnt_cet;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_tc;

  modport master (
    output cnt_pe_n, cnt_cep, cnt_cet, cnt_d,
    input  cnt_q, cnt_tc
  );

  modport slave (
    input  cnt_pe_n, cnt_cep, cnt_cet, cnt_d,
    output cnt_q, cnt_tc
  );
endinterface

// File: rtl/hc161_timer_ctrl.sv
// Programmable one-shot/periodic timer built around an external HC161-style
// counter, with a shadow counter that cross-checks cnt_q every running cycle.
module hc161_timer_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 mr,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     period,
  input  logic                 pause,
  input  logic                 stop,
  input  logic                 err_clr,
  hc161_timer_ctrl_if.master   cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic             mode_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] shadow_q;
  logic             done_q;
  logic             err_q;

  logic [WIDTH-1:0] preset;
  logic             in_run;
  logic             wrap;
  logic             reload;
  logic             mismatch;

  // (M - N) mod M is just the two's complement of N; N = 0 gives 0 (M clocks).
  assign preset   = -period_q;
  assign in_run   = (state_q == S_RUN);
  assign wrap     = in_run & cnt.cnt_tc & ~pause & ~stop;
  assign reload   = wrap & mode_q;
  assign mismatch = (cnt.cnt_q != shadow_q);

  // Reload is combinational so the counter reloads on the very edge it would
  // otherwise roll over, keeping the period exactly N clocks.
  assign cnt.cnt_pe_n = ~((state_q == S_LOAD) | reload);
  assign cnt.cnt_cep  = in_run & ~pause;
  assign cnt.cnt_cet  = in_run;
  assign cnt.cnt_d    = ((state_q == S_LOAD) | in_run) ? preset : '0;

  assign busy      = (state_q == S_LOAD) | in_run;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      period_q <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            period_q <= period;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (stop) begin
            state_q <= S_IDLE;
          end else begin
            shadow_q <= preset;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          // stop outranks everything, including a coincident wrap.
          if (stop) begin
            state_q <= S_IDLE;
          end else if (mismatch) begin
            err_q   <= 1'b1;
            state_q <= S_FAULT;
          end else if (wrap) begin
            done_q <= 1'b1;
            if (mode_q) begin
              shadow_q <= preset;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (!pause) begin
            shadow_q <= shadow_q + ONE;
          end
        end
        S_FAULT: begin
          if (err_clr) begin
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
